program_mem_arbiter: RTL

PROGRAM_MEM_ARBITER -- requirements
Module: program_mem_arbiter

---
 rtl/program_mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program memory read port among several instruction fetchers.
// One memory transaction is in flight at a time; the winner's ready stays up until it drops its valid.
module program_mem_arbiter #(
   parameter int NUM_CONSUMERS = 4,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16,
   localparam int GW           = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   output logic                               mem_read_valid,
   output logic [ADDR_BITS-1:0]               mem_read_address,
   input  logic                               mem_read_ready,
   input  logic [DATA_BITS-1:0]               mem_read_data,
   output logic                               busy,
   output logic [GW-1:0]                      grant_id
);

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_WAITING  = 2'd1,
      ARB_RELAYING = 2'd2
   } arb_state_t;

   arb_state_t                         state_q, state_d;
   logic [GW-1:0]                      rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]                      grant_id_q, grant_id_d;
   logic                               mem_valid_q, mem_valid_d;
   logic [ADDR_BITS-1:0]               mem_addr_q, mem_addr_d;
   logic [NUM_CONSUMERS-1:0]           ready_q, ready_d;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_d;
   logic                               busy_q, busy_d;

   logic [GW-1:0] win_s;
   logic [GW-1:0] idx_s;
   logic          found_s;
   int            sum_s;

   // Round-robin winner: first requesting fetcher scanning upward from rr_ptr, wrapping.
   always_comb begin
      win_s   = rr_ptr_q;
      idx_s   = rr_ptr_q;
      found_s = 1'b0;
      sum_s   = 0;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
         sum_s = int'(rr_ptr_q) + k;
         if (sum_s >= NUM_CONSUMERS) begin
            idx_s = GW'(sum_s - NUM_CONSUMERS);
         end else begin
            idx_s = GW'(sum_s);
         end
         if (!found_s && consumer_read_valid[idx_s]) begin
            found_s = 1'b1;
            win_s   = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and output-register logic of the transaction FSM.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      ready_d     = ready_q;
      data_d      = data_q;
      case (state_q)
         ARB_IDLE: begin
            if (found_s) begin
               grant_id_d  = win_s;
               mem_valid_d = 1'b1;
               mem_addr_d  = consumer_read_address[int'(win_s)*ADDR_BITS +: ADDR_BITS];
               state_d     = ARB_WAITING;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_WAITING: begin
            if (mem_read_ready) begin
               mem_valid_d                                        = 1'b0;
               data_d[int'(grant_id_q)*DATA_BITS +: DATA_BITS]    = mem_read_data;
               ready_d[grant_id_q]                                = 1'b1;
               state_d                                            = ARB_RELAYING;
            end else begin
               state_d = ARB_WAITING;
            end
         end
         ARB_RELAYING: begin
            if (!consumer_read_valid[grant_id_q]) begin
               ready_d = '0;
               state_d = ARB_IDLE;
               if (grant_id_q == GW'(NUM_CONSUMERS - 1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = grant_id_q + GW'(1);
               end
            end else begin
               state_d = ARB_RELAYING;
            end
         end
         default: begin
            state_d     = ARB_IDLE;
            mem_valid_d = 1'b0;
            ready_d     = '0;
         end
      endcase
      busy_d = (state_d != ARB_IDLE);
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         ready_q     <= '0;
         data_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         ready_q     <= ready_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
      end
   end

   assign consumer_read_ready = ready_q;
   assign consumer_read_data  = data_q;
   assign mem_read_valid      = mem_valid_q;
   assign mem_read_address    = mem_addr_q;
   assign busy                = busy_q;
   assign grant_id            = grant_id_q;

endmodule
